// File: rtl/piso_serializer8_pkg.sv
// Shared encodings for the serial word link (transmitter and receiving shift registers).
package piso_serializer8_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_SHL_MSB = 2'b00;
   localparam mode_t MODE_SHL_LSB = 2'b01;
   localparam mode_t MODE_ROT_MSB = 2'b10;
   localparam mode_t MODE_ROT_LSB = 2'b11;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   function automatic logic mode_is_rotate(input mode_t m);
      return m[1];
   endfunction

   function automatic logic mode_is_lsb_first(input mode_t m);
      return m[0];
   endfunction

endpackage

// File: rtl/piso_serializer8_if.sv
// Load handshake, bit strobe and serial output bundle of the word-link transmitter.
interface piso_serializer8_if
   import piso_serializer8_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   mode_t            mode;
   logic             load_valid;
   logic             load_ready;
   logic             bit_en;
   logic             stop;
   logic             sOut;
   logic             sValid;
   logic             sFirst;
   logic             sLast;
   logic             busy;
   logic             done;

   modport master (
      output din, mode, load_valid, bit_en, stop,
      input  load_ready, sOut, sValid, sFirst, sLast, busy, done
   );

   modport slave (
      input  din, mode, load_valid, bit_en, stop,
      output load_ready, sOut, sValid, sFirst, sLast, busy, done
   );
endinterface

// File: rtl/mod_counter.sv
// Modulo-N counter with synchronous clear; at_max flags the terminal count N-1.
module mod_counter #(
   parameter int N = 8,
   localparam int CW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          at_max
);
   assign at_max = (cnt == CW'(N - 1));

   // clr wins over inc so a fresh load always restarts at bit 0
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= at_max ? '0 : cnt + CW'(1);
      end
   end
endmodule

// File: rtl/piso_serializer8.sv
// Parallel-in/serial-out transmitter: one word per handshake, one bit per bit_en strobe.
module piso_serializer8
   import piso_serializer8_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH)
) (
   input logic             clk,
   input logic             rst,
   piso_serializer8_if.slave bus
);
   logic [0:0]       state_reg;
   logic [WIDTH-1:0] shreg_reg;
   logic [WIDTH-1:0] shreg_rot;
   mode_t            mode_reg;
   logic             done_reg;
   logic [CW-1:0]    cnt;
   logic             at_max;
   logic             in_shift;
   logic             adv;
   logic             fin;
   logic             load_ok;
   logic             load;

   assign in_shift = (state_reg == ST_SHIFT);
   assign adv      = in_shift & bus.bit_en;
   assign fin      = adv & at_max;
   assign load_ok  = ~in_shift | fin;
   assign load     = bus.load_valid & load_ok;

   mod_counter #(.N(WIDTH)) u_bit_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (load),
      .inc    (adv),
      .cnt    (cnt),
      .at_max (at_max)
   );

   // Outgoing bit re-enters the vacated end, so after WIDTH advances the word is restored
   always_comb begin
      if (mode_is_lsb_first(mode_reg)) begin
         shreg_rot = {shreg_reg[0], shreg_reg[WIDTH-1:1]};
      end else begin
         shreg_rot = {shreg_reg[WIDTH-2:0], shreg_reg[WIDTH-1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         shreg_reg <= '0;
         mode_reg  <= MODE_SHL_MSB;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= fin;
         if (load) begin
            shreg_reg <= bus.din;
            mode_reg  <= bus.mode;
            state_reg <= ST_SHIFT;
         end else if (adv) begin
            shreg_reg <= shreg_rot;
            if (fin && (!mode_is_rotate(mode_reg) || bus.stop)) begin
               state_reg <= ST_IDLE;
            end
         end
      end
   end

   assign bus.load_ready = load_ok;
   assign bus.sOut       = in_shift & (mode_is_lsb_first(mode_reg) ? shreg_reg[0]
                                                                  : shreg_reg[WIDTH-1]);
   assign bus.sValid     = in_shift;
   assign bus.sFirst     = in_shift & (cnt == '0);
   assign bus.sLast      = in_shift & at_max;
   assign bus.busy       = in_shift;
   assign bus.done       = done_reg;
endmodule

// File: tb/tb_piso_serializer8.sv
// Scoreboard bench: issued words expand into expected frame bits; a negedge monitor consumes them.
module tb_piso_serializer8;
   import piso_serializer8_pkg::*;

   localparam int W      = 8;
   localparam int BUDGET = 400;

   typedef struct packed {
      logic b;
      logic first;
      logic last;
   } bit_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   piso_serializer8_if #(.WIDTH(W)) bus ();

   piso_serializer8 #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   bit_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   en_mode     = 0;
   logic done_pend   = 1'b0;
   logic run         = 1'b0;
   logic busy_e;
   logic lr_e;
   bit_t head;

   task automatic chk(input string name, input logic act, input logic expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out after %0d cycles at %0t", name, BUDGET, $time);
   endtask

   // bit-rate strobe: constant, alternating or random
   always @(posedge clk) begin
      #1;
      case (en_mode)
         0:       bus.bit_en = 1'b1;
         1:       bus.bit_en = ~bus.bit_en;
         default: bus.bit_en = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: queue non-empty means a frame bit must be on the wire; head is that bit
   always @(negedge clk) begin
      if (run) begin
         if (rst) begin
            exp_q.delete();
            done_pend = 1'b0;
         end else begin
            busy_e = (exp_q.size() != 0);
            head   = busy_e ? exp_q[0] : '0;
            lr_e   = !busy_e || (bus.bit_en && head.last);
            chk("done", bus.done, done_pend);
            chk("busy", bus.busy, busy_e);
            chk("sValid", bus.sValid, busy_e);
            chk("load_ready", bus.load_ready, lr_e);
            chk("sOut", bus.sOut, head.b);
            chk("sFirst", bus.sFirst, head.first);
            chk("sLast", bus.sLast, head.last);
            $display("cycle %0t: sValid=%b sOut=%b exp=%b first=%b last=%b done=%b",
                     $time, bus.sValid, bus.sOut, head.b, bus.sFirst, bus.sLast, bus.done);
            done_pend = busy_e && bus.bit_en && head.last;
            if (busy_e && bus.bit_en) void'(exp_q.pop_front());
         end
      end
   end

   task automatic push_frames(input logic [W-1:0] w, input mode_t m, input int frames);
      bit_t e;
      for (int f = 0; f < frames; f++) begin
         for (int i = 0; i < W; i++) begin
            e.b     = m[0] ? w[i] : w[W-1-i];
            e.first = (i == 0);
            e.last  = (i == W - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic send_word(input logic [W-1:0] w, input mode_t m, input int frames);
      logic acc;
      acc = 1'b0;
      bus.din        = w;
      bus.mode       = m;
      bus.load_valid = 1'b1;
      for (int c = 0; c < BUDGET; c++) begin
         @(negedge clk);
         acc = bus.load_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      bus.load_valid = 1'b0;
      bus.din        = W'($urandom);
      bus.mode       = 2'($urandom);
      if (!acc) begin
         timeout_fail("accept");
      end else begin
         push_frames(w, m, frames);
         if (m[1]) begin
            // stop only matters at a frame end; raise it once the final frame is on the wire
            bus.stop = (exp_q.size() <= W);
            for (int c = 0; c < BUDGET; c++) begin
               if (exp_q.size() == 0) break;
               @(posedge clk);
               #1;
               if (exp_q.size() <= W) bus.stop = 1'b1;
            end
            if (exp_q.size() != 0) timeout_fail("rotate_drain");
            bus.stop = 1'b0;
         end else begin
            bus.stop = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic drain();
      for (int c = 0; c < BUDGET; c++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) timeout_fail("drain");
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [W-1:0] w;
      mode_t        m;
      int           fr;
      bus.din        = '0;
      bus.mode       = MODE_SHL_MSB;
      bus.load_valid = 1'b0;
      bus.bit_en     = 1'b1;
      bus.stop       = 1'b0;
      run            = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      en_mode = 0;
      send_word(8'hB1, MODE_SHL_MSB, 1);
      drain();
      send_word(8'hB1, MODE_SHL_LSB, 1);
      drain();
      send_word(8'h81, MODE_ROT_MSB, 3);
      drain();
      send_word(8'hF0, MODE_SHL_MSB, 1);
      send_word(8'h0F, MODE_SHL_MSB, 1);
      drain();

      en_mode = 1;
      send_word(8'hB1, MODE_SHL_MSB, 1);
      drain();

      // reset while bit 4 of the frame is on the wire
      en_mode = 0;
      send_word(8'hB1, MODE_SHL_MSB, 1);
      for (int c = 0; c < BUDGET; c++) begin
         if (exp_q.size() <= 5) break;
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 5) timeout_fail("reach_bit4");
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      send_word(8'h55, MODE_SHL_MSB, 1);
      drain();

      for (int t = 0; t < 40; t++) begin
         en_mode = $urandom_range(0, 2);
         w       = W'($urandom);
         m       = 2'($urandom);
         fr      = m[1] ? $urandom_range(1, 3) : 1;
         send_word(w, m, fr);
         if ($urandom_range(0, 1) == 1) drain();
      end
      drain();
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/piso_serializer8.md
Name: piso_serializer8

Overview:
- Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per enabled clock.
- Mode selects MSB-first or LSB-first order, and one-shot or continuous rotate (word repeats until stopped or replaced).
- Feeds the serial input of downstream serial-in shift registers. It is the transmit end of our serial word links.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- din  in  WIDTH  parallel word to send
- mode  in  2  00 = shift MSB-first, 01 = shift LSB-first, 10 = rotate MSB-first, 11 = rotate LSB-first
- load_valid  in  1  din/mode valid
- load_ready  out  1  block can accept a word this cycle
- bit_en  in  1  bit-rate strobe; the current bit advances only on edges where bit_en=1
- stop  in  1  request exit from rotate mode at the next frame boundary
- sOut  out  1  serial data bit
- sValid  out  1  sOut carries a frame bit
- sFirst  out  1  current bit is bit 0 of the frame
- sLast  out  1  current bit is bit WIDTH-1 of the frame
- busy  out  1  state is SHIFT
- done  out  1  one-cycle pulse after each completed frame

Behaviour:
- States: IDLE, SHIFT.
- Reset (rst=1 at a clk edge, from any state, including mid-frame): state=IDLE, shreg=0, cnt=0, mode_q=00, done=0. Outputs after reset: sOut=0, sValid=0, sFirst=0, sLast=0, busy=0, load_ready=1. Any partial frame is discarded.
- adv = SHIFT & bit_en. fin = SHIFT & bit_en & (cnt==WIDTH-1).
- load_ready = IDLE | fin. This is combinational, so a word can be loaded back-to-back with no gap bit.
- Load: when load_valid & load_ready at an edge:
  - shreg<=din, mode_q<=mode, cnt<=0, state<=SHIFT.
  - A load takes priority over repeat or exit.
- mode and din are sampled only at load. Changes mid-frame are ignored.
- Outputs in SHIFT (combinational from registers):
  - sOut = shreg[WIDTH-1] if mode_q[0]=0, else shreg[0].
  - sValid=1, sFirst=(cnt==0), sLast=(cnt==WIDTH-1), busy=1.
- Outputs in IDLE: sOut=0, sValid=0, sFirst=0, sLast=0, busy=0.
- Latency: the first bit appears on sOut in the cycle immediately after the load edge.
- On adv without fin:
  - MSB-first: shreg shifts left; LSB-first: shreg shifts right.
  - The vacated bit takes the outgoing bit in both shift and rotate modes, so shreg always holds a rotation of the word.
  - cnt<=cnt+1.
- On fin without a load:
  - Shift modes (mode_q[1]=0): state<=IDLE.
  - Rotate modes: if stop=1, state<=IDLE; otherwise cnt wraps to 0 and shreg rotates back to the original word, so the frame repeats.
- done<=fin, registered: it pulses exactly one cycle after every frame's final bit advance, including repeated rotate frames and frames followed by a back-to-back load.
- bit_en=0: all state holds, outputs stable. A load is still accepted in IDLE.
- stop is ignored in shift modes and at non-final bits. It is level-sampled only when fin is true.
- load_valid while busy and not at fin: not accepted; the source must hold the word.

Decomposition:
- Shared include/package holds:
  - mode encodings MODE_SHL_MSB=2'b00, MODE_SHL_LSB=2'b01, MODE_ROT_MSB=2'b10, MODE_ROT_LSB=2'b11
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1
- The same package is reused by the receiving shift registers.
- One natural sub-module: mod_counter (parameter N; inputs clk, rst, clr, inc; outputs cnt, at_max), used for the bit counter.

Test Plan:
- Reset, then load din=8'hB1 mode=00 with bit_en=1 constant:
  - sOut over 8 cycles = 1,0,1,1,0,0,0,1.
  - sFirst on cycle 1, sLast on cycle 8, done one cycle later.
  - busy=0 and load_ready=1 afterwards.
- Load 8'hB1 mode=01 -> sOut = 1,0,0,0,1,1,0,1, then IDLE.
- Load 8'h81 mode=10 with stop=0 for 20 enabled cycles -> sOut = 1,0,0,0,0,0,0,1 repeating; done pulses after bits 8 and 16. Raise stop during bit 24 -> IDLE after bit 24.
- Back-to-back: load 8'hF0 mode=00, hold load_valid with 8'h0F -> second word accepted at fin; 16 contiguous sValid bits = 11110000 00001111 with no gap.
- bit_en toggling every other cycle on 8'hB1 mode=00 -> each bit held 2 cycles, 16 cycles total, same bit sequence.
- Assert rst during bit 4 of 8'hB1 -> next cycle sValid=0, sOut=0, load_ready=1. A new load of 8'h55 then sends 0,1,0,1,0,1,0,1 cleanly.
